fact_host: RTL
==============

# fact_host

Bus-master sequencer that drives the memory-mapped factorial peripheral from the initiator side. It accepts a 4-bit operand on a valid/ready request port and writes it to the peripheral's n register. It then writes Go, polls the status register until done or error, and reads back the 32-bit result. The result and error status are returned on a valid/ready response port. It sits between a requesting block (test harness or future DMA/control logic) and the peripheral's A/WE/WD/RD port.

## Interface
- POLL_LIMIT, 1024, maximum POLL cycles before timeout; only used with FACT_HOST_TIMEOUT_EN.
- clk  in  1  single clock; everything is on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  host can accept a request; high only in IDLE.
- req_n  in  4  operand n.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  n! on success; 0 on error or timeout.
- rsp_err  out  1  peripheral reported error, or timeout occurred.
- rsp_timeout  out  1  poll limit exceeded; tied 0 without the macro.
- A  out  2  peripheral address.
- WE  out  1  peripheral write enable.
- WD  out  4  peripheral write data.
- RD  in  32  peripheral read data; combinational function of A.

## Operation
- Address map: 0 = n (WD[3:0]); 1 = Go (WD[0]); 2 = status (RD[1] = error, RD[0] = done); 3 = result.
- FSM states are IDLE, WR_N, WR_GO, POLL, RD_RES, RESP. Bus outputs are Moore outputs, driven from registered state and registers only.
- IDLE: A=0, WE=0, WD=0, req_ready=1.
  - On req_valid && req_ready, latch req_n and go to WR_N.
- WR_N: A=0, WE=1, WD=n_latched. Go to WR_GO.
- WR_GO: A=1, WE=1, WD=4'b0001. The peripheral clears done/error and launches its FSM at this edge. Go to POLL and clear the poll counter.
- POLL: A=2, WE=0. Sample RD[1:0] each cycle.
  - RD[1]=1 → rsp_err=1, rsp_result=0, go to RESP. Error has priority over done.
  - else RD[0]=1 → go to RD_RES.
  - else stay in POLL and increment the poll counter.
- RD_RES: A=3, WE=0. Capture RD into rsp_result, set rsp_err=0, go to RESP.
- RESP: rsp_valid=1; outputs are held stable. On rsp_ready, go to IDLE.
- n above 12 is passed through unchecked; the peripheral's error flag is reported.
- Reset values: state=IDLE, A=0, WE=0, WD=0, req_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, rsp_timeout=0, poll counter=0.

## Timing
- The request handshake edge is cycle 0. WR_N is driven in cycle 1, WR_GO in cycle 2, and the first POLL in cycle 3.
- If done is first sampled in POLL cycle k, RD_RES occurs in cycle k+1 and rsp_valid rises in cycle k+2.
- Exactly one WE cycle is issued per address; WE is never high outside WR_N and WR_GO.
- The response port has no combinational path from rsp_ready to any output. rsp_valid, rsp_result and rsp_err stay constant while rsp_valid && !rsp_ready.
- The RESP→IDLE transition costs one cycle. A request presented during RESP is accepted no earlier than the IDLE cycle.
- Reset mid-operation: WE drops immediately (asynchronous). No partial response is emitted, and the FSM restarts in IDLE. The peripheral shares Rst.
- If rsp_ready is asserted in the same cycle rsp_valid first rises, the FSM returns to IDLE at the next edge.

## Configuration
- Macro: FACT_HOST_TIMEOUT_EN.
- Defined: a $clog2(POLL_LIMIT+1)-bit poll counter is instantiated.
  - When the counter reaches POLL_LIMIT in POLL without done or error, go to RESP with rsp_err=1, rsp_timeout=1, rsp_result=0.
  - Done or error sampled in the same cycle as the limit takes priority over timeout.
- Undefined: no counter; POLL waits indefinitely; rsp_timeout is constant 0.

## Structure
- Package fact_host_pkg holds:
  - address constants FACT_ADDR_N=2'd0, FACT_ADDR_GO=2'd1, FACT_ADDR_STAT=2'd2, FACT_ADDR_RES=2'd3;
  - status bit indices FACT_STAT_DONE=0, FACT_STAT_ERR=1;
  - the state enum typedef.
- One sub-module, fact_poll_timer: a clear/increment counter with a limit-reached output, instantiated only under FACT_HOST_TIMEOUT_EN.

## Test plan
- Use the real factorial peripheral for the following:
  - req_n=5 → rsp_result=120, rsp_err=0. Exactly one WE at A=0 with WD=5, then one at A=1 with WD=1.
  - req_n=0 → rsp_result=1, rsp_err=0. req_n=12 → rsp_result=479001600.
  - req_n=13 → rsp_err=1, rsp_result=0, rsp_timeout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → outputs stable, req_ready=0 throughout. The next request is accepted one cycle after the rsp handshake.
- Timeout (macro defined, POLL_LIMIT=16): stub peripheral whose status is always 0 → rsp_timeout=1, rsp_err=1 after 16 POLL cycles.
- Assert Rst low for 1 cycle during POLL → WE=0, rsp_valid=0 immediately, req_ready=1 after release. A following req_n=3 returns 6.

Source files
------------

// File: rtl/fact_host_pkg.sv
// Shared constants and state type for the factorial bus-master sequencer.
package fact_host_pkg;

    localparam logic [1:0] FACT_ADDR_N    = 2'd0;
    localparam logic [1:0] FACT_ADDR_GO   = 2'd1;
    localparam logic [1:0] FACT_ADDR_STAT = 2'd2;
    localparam logic [1:0] FACT_ADDR_RES  = 2'd3;

    localparam int FACT_STAT_DONE = 0;
    localparam int FACT_STAT_ERR  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_N,
        ST_WR_GO,
        ST_POLL,
        ST_RD_RES,
        ST_RESP
    } fact_state_e;

endpackage

// File: rtl/fact_poll_timer.sv
// Clear/increment poll counter that saturates at LIMIT and flags when it gets there.
module fact_poll_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic Rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_limit
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_limit) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_limit = (r_cnt == W'(LIMIT));

endmodule

// File: rtl/fact_host.sv
// Sequencer that writes n and Go to the factorial peripheral, polls status and returns the result.
// Optional poll timeout is enabled with the FACT_HOST_TIMEOUT_EN macro.
module fact_host
    import fact_host_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_n,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [1:0]  A,
    output logic        WE,
    output logic [3:0]  WD,
    input  logic [31:0] RD,
    output fact_state_e o_state
);

    fact_state_e r_state;
    fact_state_e w_next;
    logic [3:0]  r_n;
    logic [31:0] r_result;
    logic        r_err;
    logic        w_done;
    logic        w_stat_err;
    logic        w_limit;

    assign w_done     = RD[FACT_STAT_DONE];
    assign w_stat_err = RD[FACT_STAT_ERR];

`ifdef FACT_HOST_TIMEOUT_EN
    logic r_timeout;

    fact_poll_timer #(.LIMIT(POLL_LIMIT)) u_timer (
        .clk     (clk),
        .Rst     (Rst),
        .i_clr   (r_state == ST_WR_GO),
        .i_inc   ((r_state == ST_POLL) && !w_done && !w_stat_err),
        .o_limit (w_limit)
    );

    // Re-evaluated every POLL cycle, so it is already 0 when leaving POLL on done or error.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_timeout <= 1'b0;
        end else if (r_state == ST_POLL) begin
            r_timeout <= !w_stat_err && !w_done && w_limit;
        end
    end

    assign rsp_timeout = r_timeout;
`else
    assign w_limit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        A      = FACT_ADDR_N;
        WE     = 1'b0;
        WD     = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_next = ST_WR_N;
            end
            ST_WR_N: begin
                WE     = 1'b1;
                WD     = r_n;
                w_next = ST_WR_GO;
            end
            ST_WR_GO: begin
                A      = FACT_ADDR_GO;
                WE     = 1'b1;
                WD     = 4'b0001;
                w_next = ST_POLL;
            end
            ST_POLL: begin
                A = FACT_ADDR_STAT;
                // Error beats done, and both beat the timeout.
                if (w_stat_err)   w_next = ST_RESP;
                else if (w_done)  w_next = ST_RD_RES;
                else if (w_limit) w_next = ST_RESP;
            end
            ST_RD_RES: begin
                A      = FACT_ADDR_RES;
                w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_n      <= 4'd0;
            r_result <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) r_n <= req_n;
                end
                ST_POLL: begin
                    if (w_stat_err || (!w_done && w_limit)) begin
                        r_result <= 32'd0;
                        r_err    <= 1'b1;
                    end
                end
                ST_RD_RES: begin
                    r_result <= RD;
                    r_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_result = r_result;
    assign rsp_err    = r_err;
    assign o_state    = r_state;

endmodule
